ncsu_bus_arbiter: RTL

Parametrised bus arbiter that grants one of NUMUNITS requesters a bus tenure. Selection is round-robin or priority, with round-robin tie-break inside the winning priority class. A grant is held until the owner drops its request, or until a hold-timeout preempts it when other units are waiting. It sits between the bus masters and the shared bus mux, and drives both a one-hot grant and an encoded owner index.

---
 rtl/ncsu_bus_arbiter_if.sv | 28 ++
 rtl/ncsu_bus_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/ncsu_bus_arbiter_if.sv
// Request/priority inputs and grant outputs shared between the bus masters and
// ncsu_bus_arbiter. Unit i priority sits at prio[i*PRIOWIDTH +: PRIOWIDTH].
interface ncsu_bus_arbiter_if #(
  parameter int unsigned NUMUNITS     = 8,
  parameter int unsigned ADDRESSWIDTH = 3,
  parameter int unsigned PRIOWIDTH    = 3
) ();

  logic                          roundORpriority;
  logic                          lock;
  logic [NUMUNITS-1:0]           request;
  logic [PRIOWIDTH*NUMUNITS-1:0] prio;
  logic [NUMUNITS-1:0]           grant;
  logic                          grant_valid;
  logic [ADDRESSWIDTH-1:0]       grant_id;
  logic                          timeout;

  modport master (
    output roundORpriority, lock, request, prio,
    input  grant, grant_valid, grant_id, timeout
  );

  modport slave (
    input  roundORpriority, lock, request, prio,
    output grant, grant_valid, grant_id, timeout
  );

endinterface

// File: rtl/ncsu_bus_arbiter.sv
// Round-robin / priority bus arbiter with per-tenure hold timeout.
// A grant is held until the owner drops its request or a contended hold expires.
module ncsu_bus_arbiter #(
  parameter int unsigned NUMUNITS     = 8,
  parameter int unsigned ADDRESSWIDTH = 3,
  parameter int unsigned PRIOWIDTH    = 3,
  parameter int unsigned MAXHOLD      = 16
) (
  input logic               clock,
  input logic               reset,
  ncsu_bus_arbiter_if.slave bus
);

  localparam int unsigned HOLDWIDTH = (MAXHOLD > 2) ? $clog2(MAXHOLD) : 1;
  localparam int unsigned HOLD_LAST = (MAXHOLD == 0) ? 0 : MAXHOLD - 1;
  localparam logic [HOLDWIDTH-1:0]    HOLD_LAST_V = HOLDWIDTH'(HOLD_LAST);
  localparam logic [ADDRESSWIDTH-1:0] LAST_UNIT   = ADDRESSWIDTH'(NUMUNITS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] next_q, next_d;
  logic [HOLDWIDTH-1:0]    hold_q, hold_d;
  logic [NUMUNITS-1:0]     grant_q, grant_d;
  logic [ADDRESSWIDTH-1:0] grant_id_q, grant_id_d;
  logic                    grant_valid_q, grant_valid_d;
  logic                    timeout_q, timeout_d;

  logic [PRIOWIDTH-1:0]    min_prio_c;
  logic [NUMUNITS-1:0]     eligible_c;
  logic [ADDRESSWIDTH-1:0] winner_c;
  logic                    win_found_c;
  logic                    others_waiting_c;
  logic                    timeout_hit_c;

  // (base + off) mod NUMUNITS, valid for off < NUMUNITS
  function automatic logic [ADDRESSWIDTH-1:0] wrap_add(input logic [ADDRESSWIDTH-1:0] base,
                                                       input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUMUNITS) s = s - NUMUNITS;
    return ADDRESSWIDTH'(s);
  endfunction

  // Most urgent priority among units that are actually requesting
  always_comb begin
    min_prio_c = '1;
    for (int i = 0; i < NUMUNITS; i++) begin
      if (bus.request[i] && (bus.prio[i*PRIOWIDTH +: PRIOWIDTH] < min_prio_c)) begin
        min_prio_c = bus.prio[i*PRIOWIDTH +: PRIOWIDTH];
      end
    end
  end

  always_comb begin
    eligible_c = '0;
    for (int i = 0; i < NUMUNITS; i++) begin
      eligible_c[i] = bus.request[i] &&
                      (!bus.roundORpriority || (bus.prio[i*PRIOWIDTH +: PRIOWIDTH] == min_prio_c));
    end
  end

  // First eligible unit scanning upward from next, wrapping at NUMUNITS
  always_comb begin
    winner_c    = '0;
    win_found_c = 1'b0;
    for (int unsigned k = 0; k < NUMUNITS; k++) begin
      if (!win_found_c && eligible_c[wrap_add(next_q, k)]) begin
        winner_c    = wrap_add(next_q, k);
        win_found_c = 1'b1;
      end
    end
  end

  assign others_waiting_c = |(bus.request & ~grant_q);
  assign timeout_hit_c    = (MAXHOLD != 0) && (hold_q == HOLD_LAST_V) &&
                            !bus.lock && others_waiting_c;

  always_comb begin
    state_d       = state_q;
    next_d        = next_q;
    hold_d        = hold_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found_c) begin
          grant_d       = NUMUNITS'(1) << winner_c;
          grant_id_d    = winner_c;
          grant_valid_d = 1'b1;
          next_d        = (winner_c == LAST_UNIT) ? '0 : winner_c + ADDRESSWIDTH'(1);
          hold_d        = '0;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        if (!bus.request[grant_id_q]) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          state_d       = IDLE;
        end else if (timeout_hit_c) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          timeout_d     = 1'b1;
          state_d       = IDLE;
        end else if (hold_q != HOLD_LAST_V) begin
          hold_d = hold_q + HOLDWIDTH'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      next_q        <= '0;
      hold_q        <= '0;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      next_q        <= next_d;
      hold_q        <= hold_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.timeout     = timeout_q;

endmodule
